// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO write-side arbiter.
// The FIFO word layout is {src_id, last, data}, with data in the low bits.
package axis_fifo_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int MAX_SRC = 16;

    function automatic int src_w_of(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic int word_w_of(input int num_src, input int data_w);
        return data_w + 1 + src_w_of(num_src);
    endfunction

    function automatic int last_bit_of(input int data_w);
        return data_w;
    endfunction

    function automatic int src_lsb_of(input int data_w);
        return data_w + 1;
    endfunction

    // First set request strictly after 'last', wrapping modulo n.
    // 'last' itself is examined last, so it holds the lowest priority.
    function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [3:0]         last,
                                           input logic [4:0]         n);
        logic [3:0] p;
        logic [3:0] win;
        logic       found;
        p     = last;
        win   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (5'(i) < n) begin
                p = ({1'b0, p} == (n - 5'd1)) ? 4'd0 : p + 4'd1;
                if (!found && req[p]) begin
                    win   = p;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_if.sv
// Bundle of the per-source AXI-Stream inputs and the FIFO write-port side.
// slave: the arbiter's view; master: the sources/write-pointer view.
interface axis_fifo_wr_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
);
    localparam int SRC_W  = axis_fifo_pkg::src_w_of(NUM_SRC);
    localparam int WORD_W = axis_fifo_pkg::word_w_of(NUM_SRC, DATA_W);

    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tready;
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tlast;
    logic                      o_wen;
    logic [WORD_W-1:0]         o_wdata;
    logic                      i_wfull;
    logic                      o_busy;
    logic [SRC_W-1:0]          o_grant;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, i_wfull,
        output s_tready, o_wen, o_wdata, o_busy, o_grant
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, i_wfull,
        input  s_tready, o_wen, o_wdata, o_busy, o_grant
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder over up to 16 requesters.
// Reusable by any arbiter that keeps its own "last served" register.
module rr_picker
    import axis_fifo_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   grant,
    output logic               any
);
    wire [MAX_SRC-1:0] req_ext;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_req
            if (gi < NUM_SRC) begin : g_used
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign grant = SRC_W'(rr_pick(req_ext, 4'(last), 5'(NUM_SRC)));
    assign any   = |req;

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among
// NUM_SRC AXI-Stream sources; each word is tagged with its source index.
module axis_fifo_wr_arbiter
    import axis_fifo_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_fifo_wr_arbiter_if.slave bus
);
    localparam int SRC_W    = src_w_of(NUM_SRC);
    localparam int WORD_W   = word_w_of(NUM_SRC, DATA_W);
    localparam int LAST_BIT = last_bit_of(DATA_W);
    localparam int SRC_LSB  = src_lsb_of(DATA_W);

    arb_state_t        state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  last_q, last_d;
    logic [SRC_W-1:0]  pick;
    logic              pick_any;
    logic              busy;
    logic              sel_valid;
    logic              sel_last;
    logic              wen;
    logic [WORD_W-1:0] wdata;

    wire [DATA_W-1:0]  data_arr [NUM_SRC];
    wire [NUM_SRC-1:0] tready_vec;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_picker (
        .req   (bus.s_tvalid),
        .last  (last_q),
        .grant (pick),
        .any   (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign data_arr[gi]   = bus.s_tdata[gi*DATA_W +: DATA_W];
            assign tready_vec[gi] = busy && (grant_q == SRC_W'(gi)) && !bus.i_wfull;
        end
    endgenerate

    assign busy      = (state_q == ARB_BUSY);
    assign sel_valid = bus.s_tvalid[grant_q];
    assign sel_last  = bus.s_tlast[grant_q];
    // Full is honoured combinationally so a beat is never pushed into a full FIFO.
    assign wen       = busy && sel_valid && !bus.i_wfull;

    always_comb begin
        wdata                       = '0;
        wdata[DATA_W-1:0]           = data_arr[grant_q];
        wdata[LAST_BIT]             = sel_last;
        wdata[WORD_W-1:SRC_LSB]     = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Grant is released only by an accepted tlast beat.
                if (wen && sel_last) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_tready = tready_vec;
    assign bus.o_wen    = wen;
    assign bus.o_wdata  = wdata;
    assign bus.o_busy   = busy;
    assign bus.o_grant  = grant_q;

endmodule
